// File: rtl/dso_capture_pkg.sv
// -----------------------------------------------------------------------------
// dso_capture_pkg
//   Shared constants and types for the DSO capture controller.
//   DEPTH       : number of sample RAM entries (power of two)
//   AW          : sample RAM address width, log2(DEPTH)
//   run_mode_t  : capture mode encoding as seen on run_mode (2'b11 acts as STOP)
//   cap_state_t : capture controller state
// -----------------------------------------------------------------------------
package dso_capture_pkg;

   localparam int unsigned DEPTH = 512;
   localparam int unsigned AW    = 9;

   typedef enum logic [1:0] {
      STOP   = 2'b00,
      NORMAL = 2'b01,
      SINGLE = 2'b10
   } run_mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SAMPLE = 2'b01,
      DONE   = 2'b10
   } cap_state_t;

endpackage

// File: rtl/capture_ptr.sv
// -----------------------------------------------------------------------------
// capture_ptr
//   Circular sample RAM write pointer plus a fill counter that saturates at
//   DEPTH.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return pointer and fill counter to 0 (wins over inc)
//   inc        : one sample written this cycle
//   ptr        : current write address, wraps DEPTH-1 -> 0
//   fill       : samples stored so far, saturating at DEPTH
//   fill_next  : value fill takes at the next edge
// -----------------------------------------------------------------------------
module capture_ptr #(
   parameter int unsigned DEPTH = dso_capture_pkg::DEPTH,
   parameter int unsigned AW    = dso_capture_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] ptr,
   output logic [AW:0]   fill,
   output logic [AW:0]   fill_next
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   always_comb begin
      fill_next = fill;
      if (clr) begin
         fill_next = '0;
      end else if (inc && (fill != FULL)) begin
         fill_next = fill + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr  <= '0;
         fill <= '0;
      end else begin
         fill <= fill_next;
         if (clr) begin
            ptr <= '0;
         end else if (inc) begin
            ptr <= ptr + 1'b1;   // DEPTH is a power of two: natural wrap
         end
      end
   end

endmodule

// File: rtl/dso_capture_ctrl.sv
// -----------------------------------------------------------------------------
// dso_capture_ctrl
//   Capture controller for the DSO sample RAM, downstream of the trigger module.
//   clk, rst_n        : clock, asynchronous active-low reset
//   run_mode          : 00 STOP, 01 NORMAL, 10 SINGLE, 11 as STOP
//   capture_done      : status bit, set by set_capture_done, cleared by software
//   trig_pos          : number of post-trigger samples (0..DEPTH-1)
//   smpl_en           : one-cycle decimated sample strobe
//   triggered         : trigger module SR-flop output
//   we, waddr         : sample RAM write enable (combinational) and address
//   armed             : enough pre-trigger history stored
//   trig_en           : trigger detection enable
//   set_capture_done  : one-cycle end-of-capture pulse
//   trace_end         : address of the last sample of the completed capture
// -----------------------------------------------------------------------------
module dso_capture_ctrl #(
   parameter int unsigned DEPTH = dso_capture_pkg::DEPTH,
   parameter int unsigned AW    = dso_capture_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    run_mode,
   input  logic          capture_done,
   input  logic [AW-1:0] trig_pos,
   input  logic          smpl_en,
   input  logic          triggered,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic          armed,
   output logic          trig_en,
   output logic          set_capture_done,
   output logic [AW-1:0] trace_end
);

   import dso_capture_pkg::*;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   cap_state_t    state, state_next;
   logic [AW:0]   fill, fill_next;
   logic [AW:0]   post_cnt, post_sum, arm_thresh;
   logic          run_active, trig_seen, complete, ptr_clr;
   logic          armed_d, trig_en_d, scd_d;
   logic [AW-1:0] trace_end_d;

   assign run_active = (run_mode == NORMAL) || (run_mode == SINGLE);
   // A trigger seen before armed is ignored entirely.
   assign trig_seen  = triggered & armed;
   assign post_sum   = post_cnt + {{AW{1'b0}}, smpl_en};
   assign arm_thresh = DEPTH_W - {1'b0, trig_pos};
   assign complete   = (state == SAMPLE) && run_active && trig_seen &&
                       ((trig_pos == '0) || (post_sum == {1'b0, trig_pos}));
   assign ptr_clr    = (state_next == IDLE);

   capture_ptr #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ptr (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (ptr_clr),
      .inc       (we),
      .ptr       (waddr),
      .fill      (fill),
      .fill_next (fill_next)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (run_active && !capture_done) state_next = SAMPLE;
         end
         SAMPLE: begin
            if (!run_active)   state_next = IDLE;
            else if (complete) state_next = DONE;
         end
         DONE: begin
            // capture_done only updates after the pulse, so ignore it while
            // the pulse is still high to avoid leaving DONE too early.
            if (!run_active) begin
               state_next = IDLE;
            end else if ((run_mode == NORMAL) && !capture_done && !set_capture_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: we is combinational, the rest are next values of registers
   always_comb begin
      // trig_pos==0 completes without a post-trigger write
      we          = smpl_en && (state == SAMPLE) && !(complete && (trig_pos == '0));
      trig_en_d   = (state_next == SAMPLE);
      armed_d     = (state_next == SAMPLE) && (fill_next >= arm_thresh);
      scd_d       = complete;
      trace_end_d = trace_end;
      if (complete) begin
         trace_end_d = we ? waddr : waddr - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed            <= 1'b0;
         trig_en          <= 1'b0;
         set_capture_done <= 1'b0;
         trace_end        <= '0;
         post_cnt         <= '0;
      end else begin
         armed            <= armed_d;
         trig_en          <= trig_en_d;
         set_capture_done <= scd_d;
         trace_end        <= trace_end_d;
         if (ptr_clr) begin
            post_cnt <= '0;
         end else if (we && trig_seen) begin
            post_cnt <= post_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dso_capture_ctrl
//   Scoreboard bench: stimulus pushes expected write addresses and expected
//   trace_end values; a negedge monitor pops them as we / set_capture_done
//   appear. capture_done is modelled as the trig_cfg status flop.
// -----------------------------------------------------------------------------
module tb_dso_capture_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] run_mode;
   logic       capture_done;
   logic [8:0] trig_pos;
   logic       smpl_en;
   logic       triggered;
   logic       sw_clr;
   logic       we;
   logic [8:0] waddr;
   logic       armed;
   logic       trig_en;
   logic       set_capture_done;
   logic [8:0] trace_end;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_waddr_q[$];
   int exp_trace_q[$];

   dso_capture_ctrl #(
      .DEPTH (512),
      .AW    (9)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .run_mode         (run_mode),
      .capture_done     (capture_done),
      .trig_pos         (trig_pos),
      .smpl_en          (smpl_en),
      .triggered        (triggered),
      .we               (we),
      .waddr            (waddr),
      .armed            (armed),
      .trig_en          (trig_en),
      .set_capture_done (set_capture_done),
      .trace_end        (trace_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // trig_cfg[5] status bit
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                capture_done <= 1'b0;
      else if (set_capture_done) capture_done <= 1'b1;
      else if (sw_clr)           capture_done <= 1'b0;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_trig_en(input string name);
      int unsigned k = 0;
      while (!trig_en && k < 10) begin
         tick();
         k++;
      end
      check(name, int'(trig_en), 1);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (we) begin
            if (exp_waddr_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: waddr=%0d, no write expected", waddr);
            end else begin
               int e;
               e = exp_waddr_q.pop_front();
               check("waddr", int'(waddr), e);
            end
         end
         if (set_capture_done) begin
            if (exp_trace_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: trace_end=%0d, no pulse expected", trace_end);
            end else begin
               int e;
               e = exp_trace_q.pop_front();
               check("trace_end", int'(trace_end), e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      run_mode  = 2'b00;
      trig_pos  = '0;
      smpl_en   = 1'b0;
      triggered = 1'b0;
      sw_clr    = 1'b0;
      tick();
      tick();
      check("rst_we", int'(we), 0);
      check("rst_waddr", int'(waddr), 0);
      check("rst_armed", int'(armed), 0);
      check("rst_trig_en", int'(trig_en), 0);
      check("rst_scd", int'(set_capture_done), 0);
      check("rst_trace_end", int'(trace_end), 0);
      rst_n = 1'b1;
      tick();

      // A: NORMAL, trig_pos=256, trigger at write 300, done at write 555
      trig_pos = 9'd256;
      run_mode = 2'b01;
      wait_trig_en("A_start");
      for (int n = 1; n <= 555; n++) begin
         if (n == 256) check("A_armed_256", int'(armed), 0);
         if (n == 257) check("A_armed_257", int'(armed), 1);
         smpl_en   = 1'b1;
         triggered = (n >= 300);
         exp_waddr_q.push_back((n - 1) % 512);
         if (n == 555) exp_trace_q.push_back(42);
         tick();
      end
      triggered = 1'b0;
      check("A_scd", int'(set_capture_done), 1);
      check("A_trig_en_done", int'(trig_en), 0);
      check("A_armed_done", int'(armed), 0);
      tick();
      tick();
      tick();
      smpl_en = 1'b0;
      check("A_trace_hold", int'(trace_end), 42);
      check("A_scd_once", int'(set_capture_done), 0);

      // B: trig_pos=0, early trigger ignored, done on first armed trigger
      trig_pos = 9'd0;
      sw_clr   = 1'b1;
      tick();
      sw_clr   = 1'b0;
      wait_trig_en("B_start");
      check("B_waddr0", int'(waddr), 0);
      for (int n = 1; n <= 512; n++) begin
         if (n == 512) check("B_armed_511", int'(armed), 0);
         smpl_en   = 1'b1;
         triggered = (n >= 100 && n <= 102);
         exp_waddr_q.push_back(n - 1);
         tick();
      end
      check("B_armed_512", int'(armed), 1);
      smpl_en   = 1'b1;
      triggered = 1'b1;
      exp_trace_q.push_back(511);
      tick();
      triggered = 1'b0;
      check("B_scd", int'(set_capture_done), 1);
      check("B_trig_en_done", int'(trig_en), 0);
      tick();
      tick();
      tick();
      smpl_en = 1'b0;

      // C: SINGLE, trig_pos=511, trigger at first armed sample
      run_mode = 2'b00;
      sw_clr   = 1'b1;
      tick();
      sw_clr   = 1'b0;
      tick();
      trig_pos = 9'd511;
      run_mode = 2'b10;
      wait_trig_en("C_start");
      check("C_waddr0", int'(waddr), 0);
      for (int n = 1; n <= 512; n++) begin
         if (n == 1) check("C_armed_1", int'(armed), 0);
         if (n == 2) check("C_armed_2", int'(armed), 1);
         smpl_en   = 1'b1;
         triggered = (n >= 2);
         exp_waddr_q.push_back(n - 1);
         if (n == 512) exp_trace_q.push_back(511);
         tick();
      end
      triggered = 1'b0;
      smpl_en   = 1'b0;
      check("C_waddr_wrap", int'(waddr), 0);
      check("C_trig_en_done", int'(trig_en), 0);
      tick();
      sw_clr = 1'b1;
      tick();
      sw_clr  = 1'b0;
      smpl_en = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      smpl_en = 1'b0;
      check("C_single_hold_trig_en", int'(trig_en), 0);
      check("C_single_hold_armed", int'(armed), 0);
      run_mode = 2'b00;
      tick();
      tick();
      trig_pos = 9'd10;
      run_mode = 2'b10;
      wait_trig_en("C_restart");
      check("C_restart_waddr", int'(waddr), 0);

      // D: STOP mid-SAMPLE
      for (int n = 1; n <= 20; n++) begin
         smpl_en   = 1'b1;
         triggered = 1'b0;
         exp_waddr_q.push_back(n - 1);
         tick();
      end
      run_mode = 2'b00;
      smpl_en  = 1'b1;
      exp_waddr_q.push_back(20);
      tick();
      smpl_en = 1'b0;
      check("D_trig_en", int'(trig_en), 0);
      check("D_waddr", int'(waddr), 0);
      check("D_trace_end", int'(trace_end), 511);
      check("D_no_scd", int'(set_capture_done), 0);
      tick();
      tick();

      // E: asynchronous reset during SAMPLE at waddr=37
      trig_pos = 9'd256;
      run_mode = 2'b01;
      wait_trig_en("E_start");
      for (int n = 1; n <= 37; n++) begin
         smpl_en = 1'b1;
         exp_waddr_q.push_back(n - 1);
         tick();
      end
      smpl_en = 1'b0;
      check("E_waddr37", int'(waddr), 37);
      #1;
      rst_n   = 1'b0;
      smpl_en = 1'b1;
      #1;
      check("E_rst_we", int'(we), 0);
      check("E_rst_waddr", int'(waddr), 0);
      check("E_rst_armed", int'(armed), 0);
      check("E_rst_trig_en", int'(trig_en), 0);
      check("E_rst_scd", int'(set_capture_done), 0);
      check("E_rst_trace_end", int'(trace_end), 0);
      run_mode = 2'b00;
      smpl_en  = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("E_idle_trig_en", int'(trig_en), 0);

      check("write_queue_empty", exp_waddr_q.size(), 0);
      check("done_queue_empty", exp_trace_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dso_capture_ctrl.md
Name: dso_capture_ctrl

Overview:
- Capture controller for the DSO sample RAM; the stage directly downstream of the trigger module.
- Runs a circular write pointer into the 512-entry sample RAM on each decimated sample strobe.
- Drives `armed` and `trig_en` to the trigger module, and consumes its `triggered` output.
- Ends the capture `trig_pos` samples after the trigger, pulses `set_capture_done`, and latches `trace_end` for readout.

Parameters:
- DEPTH, 512, number of sample RAM entries (power of two).
- AW, 9, address width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- run_mode  input  2  capture mode: 00 STOP, 01 NORMAL, 10 SINGLE, 11 treated as STOP.
- capture_done  input  1  status bit from the trigger config register (trig_cfg[5]); software clears it after reading the trace.
- trig_pos  input  AW  number of post-trigger samples, range 0..511.
- smpl_en  input  1  one-cycle sample strobe from the decimator.
- triggered  input  1  SR-flop output of the trigger module.
- we  output  1  RAM write enable.
- waddr  output  AW  RAM write address.
- armed  output  1  asserted when at least DEPTH-trig_pos samples are stored.
- trig_en  output  1  enables trigger detection.
- set_capture_done  output  1  one-cycle pulse that ends the capture; it clears the trigger flop and sets capture_done.
- trace_end  output  AW  address of the last sample written in the completed capture.

Behaviour:
- Reset values: state IDLE; we=0, waddr=0, armed=0, trig_en=0, set_capture_done=0, trace_end=0; internal counters smpl_cnt and post_cnt are 0.
- States: IDLE, SAMPLE, DONE. All outputs are registered except we, which is combinational: we = smpl_en & (state==SAMPLE).
- IDLE:
  - trig_en=0; waddr, smpl_cnt and post_cnt are held at 0.
  - Transition to SAMPLE when run_mode is NORMAL or SINGLE and capture_done=0.
- SAMPLE:
  - trig_en=1.
  - On a cycle with smpl_en=1: we=1 and waddr holds the address for that sample. waddr increments on the next edge and wraps 511->0.
  - smpl_cnt (AW+1 bits) increments per sample and saturates at DEPTH.
  - armed is registered: armed = (smpl_cnt >= DEPTH - trig_pos), with the subtraction done at AW+1 bits. It therefore rises the cycle after the qualifying sample.
  - A sample counts as post-trigger when triggered=1 in the same cycle as smpl_en. post_cnt increments per post-trigger sample.
- Completion:
  - Condition: triggered=1 and (post_cnt + (smpl_en?1:0)) == trig_pos.
  - Action: transition to DONE; pulse set_capture_done for exactly one cycle; latch trace_end = address of the last written sample (waddr-1 mod DEPTH, or waddr if it is being written this cycle).
  - trig_pos=0: completion occurs in the first cycle triggered=1 is seen, with no post-trigger write. If smpl_en=1 in that same cycle, the write is suppressed.
- DONE:
  - trig_en=0, we=0, armed cleared; trace_end is held.
  - NORMAL: once capture_done reads 0 (software cleared it), transition to IDLE, which then re-arms.
  - SINGLE: remain in DONE until run_mode=STOP, then transition to IDLE.
- STOP mid-capture: if run_mode becomes STOP while in SAMPLE, transition to IDLE on the next edge with no set_capture_done pulse; trace_end is unchanged.
- Early trigger: `triggered` while armed=0 cannot occur, because the trigger module gates on armed. If it is seen anyway, the controller ignores it (no post_cnt count) until armed=1.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous).

Decomposition:
- Shared package `dso_capture_pkg` holds:
  - DEPTH and AW constants.
  - run_mode_t enum (STOP, NORMAL, SINGLE).
  - cap_state_t enum (IDLE, SAMPLE, DONE).
- One sub-module `capture_ptr` implements the wrapping AW-bit write pointer with clear, increment, and a saturating DEPTH-limited fill counter.

Test Plan:
- Reset during SAMPLE with waddr=37 -> all outputs return to 0 immediately; state IDLE.
- NORMAL mode, trig_pos=256, smpl_en every cycle -> armed rises the cycle after the 256th write. Trigger pulse at the 300th write -> set_capture_done pulses after 256 post-trigger writes (write 555); trace_end=42 (555 mod 512, minus 1 = 42).
- trig_pos=0 -> armed only after 512 writes; set_capture_done in the first cycle triggered=1 is seen; no further we.
- trig_pos=511 with a trigger at the first armed sample -> 511 post-trigger writes; waddr wraps 511->0 correctly.
- SINGLE mode after completion with capture_done cleared -> stays in DONE and trig_en=0; run_mode STOP then SINGLE -> new capture starts from waddr=0.
- run_mode set to STOP mid-SAMPLE -> state IDLE next cycle, no set_capture_done pulse, trace_end unchanged.
